// File: rtl/mips_lite_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mips_lite_pkg
// Purpose  : Shared widths, ALU op encodings and the ID/EX bundle type.
// Revision : 1.0 - initial release
// ============================================================================
package mips_lite_pkg;

  localparam int DATA_W_DFLT = 32;
  localparam int RA_W_DFLT   = 5;

  // {binvert, sel[1:0]} as seen by the 1-bit ALU slice array
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  typedef struct packed {
    logic                   valid;
    logic [2:0]             alu_op;
    logic                   use_imm;
    logic [RA_W_DFLT-1:0]   rs_addr;
    logic [RA_W_DFLT-1:0]   rt_addr;
    logic [RA_W_DFLT-1:0]   dst_addr;
    logic                   reg_write;
    logic                   mem_read;
    logic                   mem_write;
    logic [DATA_W_DFLT-1:0] rs_data;
    logic [DATA_W_DFLT-1:0] rt_data;
    logic [DATA_W_DFLT-1:0] imm;
  } idex_t;

  function automatic logic is_known_alu_op(input logic [2:0] op);
    return op inside {ALU_AND, ALU_OR, ALU_ADD, ALU_SUB, ALU_SLT};
  endfunction

endpackage
`default_nettype wire

// File: rtl/ex_fwd_mux.sv
`default_nettype none
// ============================================================================
// Module   : ex_fwd_mux
// Purpose  : Source-operand selector; EX/MEM result beats MEM/WB, r0 never hits.
// Revision : 1.0 - initial release
// ============================================================================
module ex_fwd_mux
  import mips_lite_pkg::*;
#(
  parameter int DATA_W = DATA_W_DFLT,
  parameter int RA_W   = RA_W_DFLT,
  parameter bit FWD_EN = 1'b1
) (
  input  logic [RA_W-1:0]   i_src_addr,
  input  logic [DATA_W-1:0] i_src_data,
  input  logic              i_mem_reg_write,
  input  logic [RA_W-1:0]   i_mem_dst_addr,
  input  logic [DATA_W-1:0] i_mem_result,
  input  logic              i_wb_reg_write,
  input  logic [RA_W-1:0]   i_wb_dst_addr,
  input  logic [DATA_W-1:0] i_wb_result,
  output logic [DATA_W-1:0] o_data
);

  logic w_mem_hit;
  logic w_wb_hit;

  assign w_mem_hit = i_mem_reg_write && (i_mem_dst_addr != '0) && (i_mem_dst_addr == i_src_addr);
  assign w_wb_hit  = i_wb_reg_write  && (i_wb_dst_addr  != '0) && (i_wb_dst_addr  == i_src_addr);

  always_comb begin
    o_data = i_src_data;
    if (FWD_EN) begin
      if (w_mem_hit) begin
        o_data = i_mem_result;
      end else if (w_wb_hit) begin
        o_data = i_wb_result;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/ex_operand_stage.sv
`default_nettype none
// ============================================================================
// Module   : ex_operand_stage
// Purpose  : ID/EX register, operand forwarding and stall/bubble control.
//            Define EX_FORWARDING_EN to enable forwarding; otherwise any RAW
//            hazard on EX or MEM stalls ID.
// Revision : 1.0 - initial release
// ============================================================================
module ex_operand_stage
  import mips_lite_pkg::*;
#(
  parameter int DATA_W = DATA_W_DFLT,
  parameter int RA_W   = RA_W_DFLT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic [2:0]        id_alu_op,
  input  logic              id_use_imm,
  input  logic [RA_W-1:0]   id_rs_addr,
  input  logic [RA_W-1:0]   id_rt_addr,
  input  logic [RA_W-1:0]   id_dst_addr,
  input  logic              id_reg_write,
  input  logic              id_mem_read,
  input  logic              id_mem_write,
  input  logic [DATA_W-1:0] id_rs_data,
  input  logic [DATA_W-1:0] id_rt_data,
  input  logic [DATA_W-1:0] id_imm,
  input  logic              flush,
  input  logic              mem_reg_write,
  input  logic [RA_W-1:0]   mem_dst_addr,
  input  logic [DATA_W-1:0] mem_result,
  input  logic              wb_reg_write,
  input  logic [RA_W-1:0]   wb_dst_addr,
  input  logic [DATA_W-1:0] wb_result,
  output logic              stall_id,
  output logic              ex_valid,
  output logic [DATA_W-1:0] ex_a,
  output logic [DATA_W-1:0] ex_b,
  output logic [DATA_W-1:0] ex_store_data,
  output logic              ex_binvert,
  output logic [1:0]        ex_sel,
  output logic [RA_W-1:0]   ex_dst_addr,
  output logic              ex_reg_write,
  output logic              ex_mem_read,
  output logic              ex_mem_write
);

`ifdef EX_FORWARDING_EN
  localparam bit FWD_EN = 1'b1;
`else
  localparam bit FWD_EN = 1'b0;
`endif

  idex_t             r_ex;
  idex_t             w_ex_next;
  logic              w_rt_used;
  logic              w_ex_hit;
  logic              w_mem_hit;
  logic              w_hazard;
  logic              w_load;
  logic [DATA_W-1:0] w_rs_fwd;
  logic [DATA_W-1:0] w_rt_fwd;

  // rt is only a true source for R-type ops and for stores (store data)
  assign w_rt_used = !id_use_imm || id_mem_write;
  assign w_ex_hit  = (r_ex.dst_addr != '0) &&
                     ((r_ex.dst_addr == id_rs_addr) || (w_rt_used && (r_ex.dst_addr == id_rt_addr)));
  assign w_mem_hit = (mem_dst_addr != '0) &&
                     ((mem_dst_addr == id_rs_addr) || (w_rt_used && (mem_dst_addr == id_rt_addr)));

  always_comb begin
    w_hazard = 1'b0;
    if (FWD_EN) begin
      w_hazard = r_ex.valid && r_ex.mem_read && w_ex_hit;
    end else begin
      w_hazard = (r_ex.valid && r_ex.reg_write && w_ex_hit) || (mem_reg_write && w_mem_hit);
    end
  end

  assign stall_id = id_valid && !flush && w_hazard;
  assign w_load   = id_valid && !flush && !w_hazard;

  always_comb begin
    w_ex_next        = '0;
    w_ex_next.alu_op = ALU_AND;
    if (w_load) begin
      w_ex_next.valid     = 1'b1;
      w_ex_next.alu_op    = id_alu_op;
      w_ex_next.use_imm   = id_use_imm;
      w_ex_next.rs_addr   = id_rs_addr;
      w_ex_next.rt_addr   = id_rt_addr;
      w_ex_next.dst_addr  = id_dst_addr;
      w_ex_next.reg_write = id_reg_write;
      w_ex_next.mem_read  = id_mem_read;
      w_ex_next.mem_write = id_mem_write;
      w_ex_next.rs_data   = id_rs_data;
      w_ex_next.rt_data   = id_rt_data;
      w_ex_next.imm       = id_imm;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ex <= '0;
    end else begin
      r_ex <= w_ex_next;
    end
  end

  ex_fwd_mux #(.DATA_W(DATA_W), .RA_W(RA_W), .FWD_EN(FWD_EN)) u_fwd_rs (
    .i_src_addr      (r_ex.rs_addr),
    .i_src_data      (r_ex.rs_data),
    .i_mem_reg_write (mem_reg_write),
    .i_mem_dst_addr  (mem_dst_addr),
    .i_mem_result    (mem_result),
    .i_wb_reg_write  (wb_reg_write),
    .i_wb_dst_addr   (wb_dst_addr),
    .i_wb_result     (wb_result),
    .o_data          (w_rs_fwd)
  );

  ex_fwd_mux #(.DATA_W(DATA_W), .RA_W(RA_W), .FWD_EN(FWD_EN)) u_fwd_rt (
    .i_src_addr      (r_ex.rt_addr),
    .i_src_data      (r_ex.rt_data),
    .i_mem_reg_write (mem_reg_write),
    .i_mem_dst_addr  (mem_dst_addr),
    .i_mem_result    (mem_result),
    .i_wb_reg_write  (wb_reg_write),
    .i_wb_dst_addr   (wb_dst_addr),
    .i_wb_result     (wb_result),
    .o_data          (w_rt_fwd)
  );

  assign ex_valid      = r_ex.valid;
  assign ex_a          = w_rs_fwd;
  assign ex_b          = r_ex.use_imm ? r_ex.imm : w_rt_fwd;
  assign ex_store_data = w_rt_fwd;
  assign ex_binvert    = r_ex.alu_op[2];
  assign ex_sel        = r_ex.alu_op[1:0];
  assign ex_dst_addr   = r_ex.dst_addr;
  assign ex_reg_write  = r_ex.reg_write;
  assign ex_mem_read   = r_ex.mem_read;
  assign ex_mem_write  = r_ex.mem_write;

endmodule
`default_nettype wire

// File: tb/tb_ex_operand_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_ex_operand_stage
// Purpose  : Self-checking bench: architectural (in-order) register model plus
//            a MEM/WB/register-file environment; honours EX_FORWARDING_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ex_operand_stage;
  import mips_lite_pkg::*;

`ifdef EX_FORWARDING_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  typedef struct packed {
    logic        valid;
    logic [2:0]  op;
    logic        use_imm, rw, mr, mw;
    logic [4:0]  rs, rt, dst;
    logic [31:0] imm, a, b, sd, res;
  } ins_t;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic id_valid = 0, id_use_imm = 0, id_reg_write = 0, id_mem_read = 0, id_mem_write = 0, flush = 0;
  logic [2:0]  id_alu_op = '0;
  logic [4:0]  id_rs_addr = '0, id_rt_addr = '0, id_dst_addr = '0, mem_dst_addr = '0, wb_dst_addr = '0;
  logic [31:0] id_rs_data = '0, id_rt_data = '0, id_imm = '0, mem_result = '0, wb_result = '0;
  logic        mem_reg_write = 0, wb_reg_write = 0;
  logic        stall_id, ex_valid, ex_binvert, ex_reg_write, ex_mem_read, ex_mem_write;
  logic [1:0]  ex_sel;
  logic [4:0]  ex_dst_addr;
  logic [31:0] ex_a, ex_b, ex_store_data;

  ex_operand_stage #(.DATA_W(32), .RA_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_alu_op(id_alu_op), .id_use_imm(id_use_imm),
    .id_rs_addr(id_rs_addr), .id_rt_addr(id_rt_addr), .id_dst_addr(id_dst_addr),
    .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
    .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm), .flush(flush),
    .mem_reg_write(mem_reg_write), .mem_dst_addr(mem_dst_addr), .mem_result(mem_result),
    .wb_reg_write(wb_reg_write), .wb_dst_addr(wb_dst_addr), .wb_result(wb_result),
    .stall_id(stall_id), .ex_valid(ex_valid), .ex_a(ex_a), .ex_b(ex_b), .ex_store_data(ex_store_data),
    .ex_binvert(ex_binvert), .ex_sel(ex_sel), .ex_dst_addr(ex_dst_addr),
    .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] rf   [32];   // physical register file seen by ID (lags in-flight writes)
  logic [31:0] arch [32];   // in-order architectural state: what operands must be
  ins_t        cur, ex_m, mem_m, wb_m, next_ex;
  bit          id_v, flsh, exp_stall, last_accept;
  int          st;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] alu(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      ALU_AND: return a & b;
      ALU_OR:  return a | b;
      ALU_ADD: return a + b;
      ALU_SUB: return a - b;
      ALU_SLT: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  function automatic ins_t mk(input logic [2:0] op, input int rs, input int rt, input int dst,
                              input bit ui, input logic [31:0] imm, input bit rw, input bit mr, input bit mw);
    ins_t i = '0;
    i.op = op; i.rs = 5'(rs); i.rt = 5'(rt); i.dst = 5'(dst);
    i.use_imm = ui; i.imm = imm; i.rw = rw; i.mr = mr; i.mw = mw;
    return i;
  endfunction

  function automatic ins_t rand_ins();
    ins_t i = '0;
    logic [2:0] ops [5] = '{ALU_AND, ALU_OR, ALU_ADD, ALU_SUB, ALU_SLT};
    int k = $urandom_range(0, 9);
    i.rs = 5'($urandom_range(0, 7)); i.rt = 5'($urandom_range(0, 7)); i.dst = 5'($urandom_range(0, 7));
    i.imm = $urandom;
    if (k < 5) begin
      i.op = ops[$urandom_range(0, 4)]; i.rw = 1;
    end else if (k < 7) begin
      i.op = ($urandom_range(0, 1) != 0) ? ALU_ADD : ALU_OR; i.use_imm = 1; i.rt = i.dst; i.rw = 1;
    end else if (k < 9) begin
      i.op = ALU_ADD; i.use_imm = 1; i.rt = i.dst; i.rw = 1; i.mr = 1; i.imm = 32'($urandom_range(0, 255));
    end else begin
      i.op = ALU_ADD; i.use_imm = 1; i.mw = 1; i.dst = 0; i.imm = 32'($urandom_range(0, 255));
    end
    return i;
  endfunction

  // register file is write-first: the WB write is visible to ID in the same cycle
  function automatic logic [31:0] rd(input logic [4:0] r);
    if (wb_m.valid && wb_m.rw && wb_m.dst != 0 && wb_m.dst == r) return wb_m.res;
    return rf[r];
  endfunction

  function automatic bit reads(input ins_t p, input ins_t c);
    return (p.dst != 0) && ((p.dst == c.rs) || ((p.dst == c.rt) && (!c.use_imm || c.mw)));
  endfunction

  task automatic begin_cycle();
    bit hz;
    if (wb_m.valid && wb_m.rw && wb_m.dst != 0) rf[wb_m.dst] = wb_m.res;
    wb_m = mem_m; mem_m = ex_m; ex_m = next_ex;
    mem_reg_write = mem_m.valid && mem_m.rw; mem_dst_addr = mem_m.dst; mem_result = mem_m.res;
    wb_reg_write  = wb_m.valid && wb_m.rw;   wb_dst_addr  = wb_m.dst;  wb_result  = wb_m.res;
    id_valid = id_v; flush = flsh;
    id_alu_op = cur.op; id_use_imm = cur.use_imm; id_rs_addr = cur.rs; id_rt_addr = cur.rt;
    id_dst_addr = cur.dst; id_reg_write = cur.rw; id_mem_read = cur.mr; id_mem_write = cur.mw;
    id_rs_data = rd(cur.rs); id_rt_data = rd(cur.rt); id_imm = cur.imm;
    #2;
    if (FWD) hz = ex_m.valid && ex_m.mr && reads(ex_m, cur);
    else     hz = (ex_m.valid && ex_m.rw && reads(ex_m, cur)) || (mem_m.valid && mem_m.rw && reads(mem_m, cur));
    exp_stall = id_v && !flsh && hz;
    chk("stall_id", 32'(stall_id), 32'(exp_stall));
    chk("ex_valid", 32'(ex_valid), 32'(ex_m.valid));
    chk("ex_binvert", 32'(ex_binvert), 32'(ex_m.op[2]));
    chk("ex_sel", 32'(ex_sel), 32'(ex_m.op[1:0]));
    chk("ex_dst", 32'(ex_dst_addr), 32'(ex_m.dst));
    chk("ex_ctl", {29'd0, ex_reg_write, ex_mem_read, ex_mem_write}, {29'd0, ex_m.rw, ex_m.mr, ex_m.mw});
    chk("ex_a", ex_a, ex_m.a);
    chk("ex_b", ex_b, ex_m.b);
    if (!ex_m.valid || ex_m.mw || !ex_m.use_imm) chk("ex_store_data", ex_store_data, ex_m.sd);
  endtask

  task automatic end_cycle();
    ins_t e;
    last_accept = id_v && !flsh && !exp_stall;
    next_ex = '0;
    if (last_accept) begin
      e = cur; e.valid = 1;
      e.a  = arch[cur.rs];
      e.sd = arch[cur.rt];
      e.b  = cur.use_imm ? cur.imm : e.sd;
      e.res = cur.mr ? ((e.a + e.b) ^ 32'hA5A5_0000) : alu(cur.op, e.a, e.b);
      if (e.rw && e.dst != 0) arch[e.dst] = e.res;
      next_ex = e;
    end
    @(posedge clk); #1;
  endtask

  task automatic finish_issue(output int stalls);
    stalls = 0;
    end_cycle();
    for (int k = 0; k < 6 && !last_accept; k++) begin
      stalls++;
      begin_cycle();
      end_cycle();
    end
    chk("issue_accepted", 32'(last_accept), 32'd1);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    mem_reg_write = 0; mem_dst_addr = 0; mem_result = 0;
    wb_reg_write = 0;  wb_dst_addr = 0;  wb_result = 0;
    #1;
    chk("rst_stall", 32'(stall_id), 32'd0);
    chk("rst_valid", 32'(ex_valid), 32'd0);
    chk("rst_ctl", {26'd0, ex_binvert, ex_sel, ex_reg_write, ex_mem_read, ex_mem_write}, 32'd0);
    chk("rst_dst", 32'(ex_dst_addr), 32'd0);
    chk("rst_a", ex_a, 32'd0);
    chk("rst_b", ex_b, 32'd0);
    chk("rst_sd", ex_store_data, 32'd0);
    @(posedge clk); #2;
    rst_n = 1'b1;
    ex_m = '0; mem_m = '0; wb_m = '0; next_ex = '0;
    for (int i = 0; i < 32; i++) arch[i] = rf[i];
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    ins_t fill;
    for (int i = 0; i < 32; i++) rf[i] = (i == 0) ? 32'd0 : $urandom;
    ex_m = '0; mem_m = '0; wb_m = '0; next_ex = '0; cur = '0; id_v = 0; flsh = 0;
    #2;
    do_reset();
    rf[1] = 32'd5; rf[2] = 32'd7; arch[1] = 32'd5; arch[2] = 32'd7;
    fill = mk(ALU_AND, 1, 2, 9, 0, 0, 1, 0, 0);
    id_v = 1;

    // ADD r3,r1,r2 then SUB r4,r3,r3
    cur = mk(ALU_ADD, 1, 2, 3, 0, 0, 1, 0, 0); begin_cycle(); finish_issue(st);
    cur = mk(ALU_SUB, 3, 3, 4, 0, 0, 1, 0, 0); begin_cycle();
    chk("add_a", ex_a, 32'd5); chk("add_b", ex_b, 32'd7);
    chk("add_sel", 32'(ex_sel), 32'd2); chk("add_binv", 32'(ex_binvert), 32'd0);
    finish_issue(st);
    chk("sub_stalls", 32'(st), FWD ? 32'd0 : 32'd2);
    cur = mk(ALU_OR, 1, 2, 3, 0, 0, 1, 0, 0); begin_cycle();
    chk("sub_a", ex_a, 32'd12); chk("sub_b", ex_b, 32'd12); chk("sub_binv", 32'(ex_binvert), 32'd1);
    finish_issue(st);

    // r3 written by OR (=7, older) and ADD (=10, younger): younger must win
    cur = mk(ALU_ADD, 1, 1, 3, 0, 0, 1, 0, 0); begin_cycle(); finish_issue(st);
    cur = mk(ALU_SUB, 3, 3, 4, 0, 0, 1, 0, 0); begin_cycle(); finish_issue(st);
    cur = fill; begin_cycle();
    chk("prio_a", ex_a, 32'd10); chk("prio_b", ex_b, 32'd10);
    finish_issue(st);

    // load-use: LW r5,0(r1) then ADD r6,r5,r1
    cur = mk(ALU_ADD, 1, 5, 5, 1, 0, 1, 1, 0); begin_cycle(); finish_issue(st);
    cur = mk(ALU_ADD, 5, 1, 6, 0, 0, 1, 0, 0); begin_cycle();
    chk("lu_stall", 32'(stall_id), 32'd1);
    finish_issue(st);
    chk("lu_stalls", 32'(st), FWD ? 32'd1 : 32'd2);
    cur = fill; begin_cycle();
    chk("lu_a", ex_a, 32'hA5A5_0005); chk("lu_b", ex_b, 32'd5);
    finish_issue(st);

    // stall condition with flush: flush wins
    cur = mk(ALU_ADD, 1, 5, 5, 1, 0, 1, 1, 0); begin_cycle(); finish_issue(st);
    cur = mk(ALU_ADD, 5, 1, 6, 0, 0, 1, 0, 0); flsh = 1; begin_cycle();
    chk("flush_stall", 32'(stall_id), 32'd0);
    end_cycle();
    flsh = 0; cur = fill; begin_cycle();
    chk("flush_bubble", 32'(ex_valid), 32'd0);
    finish_issue(st);

    // r0 never forwarded and never stalls
    cur = mk(ALU_ADD, 1, 2, 0, 0, 0, 1, 0, 0); begin_cycle(); finish_issue(st);
    cur = mk(ALU_ADD, 0, 0, 7, 0, 0, 1, 0, 0); begin_cycle();
    chk("r0_nostall", 32'(stall_id), 32'd0);
    finish_issue(st);
    cur = fill; begin_cycle();
    chk("r0_a", ex_a, 32'd0); chk("r0_b", ex_b, 32'd0);
    finish_issue(st);
    cur = mk(ALU_ADD, 1, 0, 0, 1, 0, 1, 1, 0); begin_cycle(); finish_issue(st);
    cur = mk(ALU_ADD, 0, 1, 7, 0, 0, 1, 0, 0); begin_cycle();
    chk("ldr0_nostall", 32'(stall_id), 32'd0);
    finish_issue(st);

    // randomized traffic with bubbles, flushes and one asynchronous reset
    cur = rand_ins();
    for (int c = 0; c < 3000; c++) begin
      id_v = ($urandom_range(0, 99) < 85);
      flsh = ($urandom_range(0, 99) < 8);
      begin_cycle();
      if (c == 1500) begin
        do_reset();
        continue;
      end
      end_cycle();
      if (last_accept || (id_v && flsh)) cur = rand_ins();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ex_operand_stage.md
# ex_operand_stage

ID/EX pipeline stage of the pipelined MIPS-lite CPU. Registers decoded instruction fields from ID and presents the 32-bit ALU slice array with operands `a`/`b` and controls `binvert`/`sel`. It resolves data hazards by forwarding from EX/MEM and MEM/WB and detects load-use hazards. It sits directly upstream of the ripple ALU built from 1-bit slices and owns the ID-stall and bubble-insertion logic.

## Interface
- `DATA_W`, 32, operand/result width (ALU slice count)
- `RA_W`, 5, register-address width
- `clk` in 1: the single clock; every register updates on its rising edge
- `rst_n` in 1: asynchronous, active-low reset
- `id_valid` in 1: ID holds a valid instruction
- `id_alu_op` in 3: `{binvert, sel[1:0]}`
- `id_use_imm` in 1: operand B is the immediate
- `id_rs_addr`, `id_rt_addr`, `id_dst_addr` in RA_W: source and destination registers
- `id_reg_write`, `id_mem_read`, `id_mem_write` in 1: control bits
- `id_rs_data`, `id_rt_data`, `id_imm` in DATA_W: register-file reads and the sign-extended immediate
- `flush` in 1: taken branch; kill the ID instruction
- `mem_reg_write` in 1, `mem_dst_addr` in RA_W, `mem_result` in DATA_W: EX/MEM writeback info
- `wb_reg_write` in 1, `wb_dst_addr` in RA_W, `wb_result` in DATA_W: MEM/WB writeback info
- `stall_id` out 1: combinational; hold PC and IF/ID
- `ex_valid` out 1: EX holds a real instruction
- `ex_a`, `ex_b`, `ex_store_data` out DATA_W: ALU operands and store data (forwarded)
- `ex_binvert` out 1, `ex_sel` out 2: ALU controls; `ex_binvert` also drives the LSB carry-in
- `ex_dst_addr` out RA_W; `ex_reg_write`, `ex_mem_read`, `ex_mem_write` out 1

## Operation
- The pipeline register loads the ID fields when `id_valid && !stall_id && !flush`.
- Otherwise it loads a bubble: `ex_valid`, `reg_write`, `mem_read`, `mem_write` = 0; `alu_op` = 0 (AND); `dst` = 0. Data fields are don't-care but are driven to 0.
- Load-use: `stall_id = id_valid && !flush && ex_valid && ex_mem_read && ex_dst != 0 && (ex_dst == id_rs || (ex_dst == id_rt && (!id_use_imm || id_mem_write)))`.
- Forwarding applies to each registered source (rs, rt), using registered rs/rt addresses and data:
  - If `mem_reg_write && mem_dst != 0 && mem_dst == src`, select `mem_result`.
  - Else if `wb_reg_write && wb_dst != 0 && wb_dst == src`, select `wb_result`.
  - Else select the registered data. MEM has priority over WB.
- Outputs: `ex_a` = forwarded rs; `ex_b` = `use_imm` ? registered imm : forwarded rt; `ex_store_data` = forwarded rt.
- Register 0 is never forwarded and never causes a stall.
- `flush` takes priority over a stall: a bubble is loaded and `stall_id` = 0.

## Timing
- Latency is 1 cycle: ID fields accepted at edge N appear on `ex_*` after edge N.
- Forwarding is combinational from the stage register and the mem/wb inputs, with zero added latency.
- `stall_id` is combinational in the same cycle. A stalled instruction is re-presented by ID and accepted on the next non-stalled edge. A load-use stall lasts exactly 1 cycle.
- Reset (asynchronous, any time, including mid-stall) clears all registers: `ex_valid` = 0, all controls = 0, `ex_a`/`ex_b`/`ex_store_data` = 0 (no forward match with dst 0), `stall_id` = 0.
- When `id_valid` = 0, a bubble is loaded every edge.

## Configuration
- `EX_FORWARDING_EN` defined: forwarding as above.
- Undefined: no forwarding; `ex_a`/`ex_b`/`ex_store_data` come from registered data only.
  - `stall_id` then asserts for any RAW hazard: `id_valid && !flush` and id_rs or id_rt (rt qualified as above) equals a nonzero dst of an EX (`ex_valid && ex_reg_write`) or MEM (`mem_reg_write`) instruction.
  - The register file is write-first, so WB needs no stall.

## Structure
- Package `mips_lite_pkg` holds:
  - ALU op constants `ALU_AND`=3'b000, `ALU_OR`=3'b001, `ALU_ADD`=3'b010, `ALU_SUB`=3'b110, `ALU_SLT`=3'b111.
  - `DATA_W`/`RA_W` defaults.
  - The ID/EX bundle typedef.
- One sub-module, `ex_fwd_mux`: a source-operand forwarding selector, instantiated twice (rs, rt).

## Test plan
- Reset asserted mid-stream -> all `ex_*` = 0 and `stall_id` = 0 immediately. First valid `ADD r3,r1,r2` (r1=5, r2=7) after release -> `ex_a`=5, `ex_b`=7, `ex_sel`=2'b10, `ex_binvert`=0.
- `ADD r3,...` in MEM (`mem_result`=0x10) and `SUB r4,r3,r3` in EX -> `ex_a`=`ex_b`=0x10, `ex_binvert`=1. Same with WB=0x20 and MEM=0x10 both targeting r3 -> 0x10 (MEM priority).
- `LW r5` in EX, ID `ADD r6,r5,r1` -> `stall_id`=1 for one cycle and a bubble is loaded (`ex_valid`=0). The next edge accepts the ADD, which gets WB/MEM-forwarded load data.
- Stall condition plus `flush`=1 in the same cycle -> `stall_id`=0 and a bubble is loaded.
- Dst r0 in MEM with `mem_result`=0xDEAD and ID reading r0 -> no forward; `ex_a` = registered 0. `LW r0` followed by a use -> no stall.
- `EX_FORWARDING_EN` undefined: ADD r3 in EX, next instruction reads r3 -> `stall_id`=1 for 2 cycles, then operands come from register-file data.
